// File: rtl/out_buf_wr_sched_pkg.sv
// Shared types and helpers for the output-buffer write scheduler.
package out_buf_wr_sched_pkg;

    // Scheduler FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    // Width of a lane index; never below one bit so single-lane builds elaborate
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter: rotating-priority search from a pointer that moves
// past the last winner whenever the caller confirms the grant was taken.
module rr_arbiter_n
    import out_buf_wr_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IDX_W = idx_w(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             enable,
    input  logic             advance,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] ptr;
    logic             found;
    int               j;

    // First requester at or after ptr, wrapping modulo N_REQ
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (enable && !found && req[IDX_W'(j)]) begin
                found             = 1'b1;
                gnt[IDX_W'(j)]    = 1'b1;
                idx               = IDX_W'(j);
            end
        end
    end

    // Pointer moves just past the lane that actually transferred; it is
    // never cleared between tiles or frames, only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (advance)
            ptr <= (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
    end

endmodule

// File: rtl/out_buf_wr_sched.sv
// Write-side scheduler for the output result buffer: shares the single
// write port between N_REQ lanes, groups beats into tiles and waits for
// the buffer's done pulse between tiles.
module out_buf_wr_sched
    import out_buf_wr_sched_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int WIDTH      = 256,
    parameter int log2_DEPTH = 3,
    parameter int TILE_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [log2_DEPTH-1:0]   cfg_dat_num,
    input  logic [TILE_W-1:0]       cfg_tile_num,
    input  logic [N_REQ-1:0]        req_vld,
    input  logic [N_REQ*WIDTH-1:0]  req_dat,
    output logic [N_REQ-1:0]        req_rdy,
    output logic                    buf_dat_vld,
    output logic [WIDTH-1:0]        buf_dat,
    output logic [log2_DEPTH-1:0]   buf_dat_num,
    input  logic                    buf_done,
    output logic                    busy,
    output logic                    tile_done,
    output logic                    all_done
);

    localparam int IDX_W = idx_w(N_REQ);

    state_t                state, state_nxt;
    logic [log2_DEPTH-1:0] beat_cnt, dat_num_q;
    logic [TILE_W-1:0]     tile_cnt, tile_num_q;
    logic [N_REQ-1:0]      gnt;
    logic [IDX_W-1:0]      gnt_idx;
    logic [WIDTH-1:0]      sel_dat;
    logic                  run, hs, last_beat, last_tile;
    logic                  tile_done_nxt, all_done_nxt;

    assign run       = (state == ST_RUN);
    assign last_beat = (beat_cnt == dat_num_q);
    assign last_tile = (tile_cnt == tile_num_q);

    rr_arbiter_n #(.N_REQ(N_REQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_vld),
        .enable  (run),
        .advance (hs),
        .gnt     (gnt),
        .idx     (gnt_idx)
    );

    // Grants only go to valid lanes, so any grant is a handshake
    assign req_rdy = gnt;
    assign hs      = |gnt;

    // Data of the granted lane
    always_comb begin
        sel_dat = '0;
        for (int i = 0; i < N_REQ; i++)
            if (gnt_idx == IDX_W'(i)) sel_dat = req_dat[i*WIDTH +: WIDTH];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state and completion pulses; stray start/buf_done are ignored
    always_comb begin
        state_nxt     = state;
        tile_done_nxt = 1'b0;
        all_done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (hs && last_beat) state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (buf_done) begin
                    tile_done_nxt = 1'b1;
                    if (last_tile) begin
                        all_done_nxt = 1'b1;
                        state_nxt    = ST_IDLE;
                    end else begin
                        state_nxt    = ST_RUN;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Config latches plus beat/tile counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat_num_q  <= '0;
            tile_num_q <= '0;
            beat_cnt   <= '0;
            tile_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dat_num_q  <= cfg_dat_num;
                        tile_num_q <= cfg_tile_num;
                        beat_cnt   <= '0;
                        tile_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    // Last beat leaves beat_cnt parked; it is cleared when the tile is acknowledged
                    if (hs && !last_beat) beat_cnt <= beat_cnt + 1'b1;
                end
                ST_WAIT_DONE: begin
                    if (buf_done && !last_tile) begin
                        tile_cnt <= tile_cnt + 1'b1;
                        beat_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered completion pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_done <= 1'b0;
            all_done  <= 1'b0;
        end else begin
            tile_done <= tile_done_nxt;
            all_done  <= all_done_nxt;
        end
    end

    // Write stage: one-cycle latency, data held while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_dat_vld <= 1'b0;
            buf_dat     <= '0;
        end else begin
            buf_dat_vld <= hs;
            if (hs) buf_dat <= sel_dat;
        end
    end

    assign buf_dat_num = dat_num_q;
    // all_done keeps busy up through the final pulse cycle after the FSM is back in IDLE
    assign busy        = (state != ST_IDLE) | all_done;

endmodule
